// File: rtl/soff_csr_pkg.sv
// Shared definitions for SOFF sub-block CSR windows.
//   - register offsets inside a sub-block window (in 64-bit register units)
//   - CCI-P MMIO length encodings
//   - rx/tx MMIO structs carried by sub_csr_if
//   - t_csr_rd_req: decoded read request handed to the read response pipeline
package soff_csr_pkg;

    typedef logic [3:0] t_csr_idx;

    localparam t_csr_idx CSR_ID     = 4'd0;
    localparam t_csr_idx CSR_CTRL   = 4'd1;
    localparam t_csr_idx CSR_STATUS = 4'd2;
    localparam t_csr_idx CSR_CYCLE  = 4'd3;
    localparam t_csr_idx CSR_ARG0   = 4'd4;

    localparam logic [1:0] CCIP_LEN_4B  = 2'b00;
    localparam logic [1:0] CCIP_LEN_8B  = 2'b01;
    localparam logic [1:0] CCIP_LEN_64B = 2'b10;

    typedef struct packed {
        logic [15:0] address;   // MMIO dword address
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_csr_rx_hdr;

    typedef struct packed {
        t_csr_rx_hdr hdr;
        logic [63:0] data;
        logic        wrValid;
        logic        rdValid;
    } t_csr_rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_csr_tx_hdr;

    typedef struct packed {
        t_csr_tx_hdr hdr;
        logic [63:0] data;
        logic        mmioRdValid;
    } t_csr_tx;

    typedef struct packed {
        t_csr_idx   idx;
        logic       hi;     // upper dword selected (4B access)
        logic       is32;   // 4B access
        logic [8:0] tid;
    } t_csr_rd_req;

    // Byte lanes touched by a write: all 64 bits for 8B, one dword for 4B.
    function automatic logic [63:0] csr_lane_mask(input logic is32, input logic hi);
        logic [63:0] mask;
        if (!is32) begin
            mask = '1;
        end else if (hi) begin
            mask = {32'hFFFF_FFFF, 32'h0};
        end else begin
            mask = {32'h0, 32'hFFFF_FFFF};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sub_csr_if.sv
// MMIO link between the AFU CSR hub and one sub-block.
//   rx : decoded MMIO requests, hub -> sub-block
//   tx : read responses, sub-block -> hub
// Modports:
//   to_afu : sub-block side (rx in, tx out)
//   to_hub : hub side (rx out, tx in)
interface sub_csr_if;
    import soff_csr_pkg::*;

    t_csr_rx rx;
    t_csr_tx tx;

    modport to_afu (input rx, output tx);
    modport to_hub (output rx, input tx);

endinterface

// File: rtl/soff_csr_rd_pipe.sv
// Two-stage MMIO read response pipeline.
//   Stage 1 registers the decoded request; stage 2 muxes register data (via rd_idx_o/rd_data_i)
//   and registers the tx response. One response per request, in order, no backpressure.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (drops in-flight reads)
//   req_valid_i  : decoded read request valid this cycle
//   req_i        : decoded read request
//   rd_idx_o     : register index for the external read mux
//   rd_data_i    : 64-bit register value for rd_idx_o
//   tx_o         : registered read response
module soff_csr_rd_pipe
    import soff_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  t_csr_rd_req req_i,
    output t_csr_idx    rd_idx_o,
    input  logic [63:0] rd_data_i,
    output t_csr_tx     tx_o
);

    logic        s1_valid_q, s1_valid_d;
    t_csr_rd_req s1_req_q, s1_req_d;
    t_csr_tx     tx_q, tx_d;
    logic [31:0] sel_dword;

    assign rd_idx_o = s1_req_q.idx;
    assign tx_o     = tx_q;

    always_comb begin
        s1_valid_d = req_valid_i;
        s1_req_d   = req_i;

        sel_dword = s1_req_q.hi ? rd_data_i[63:32] : rd_data_i[31:0];

        // Idle cycles drive an all-zero response.
        tx_d = '0;
        if (s1_valid_q) begin
            tx_d.mmioRdValid = 1'b1;
            tx_d.hdr.tid     = s1_req_q.tid;
            tx_d.data        = s1_req_q.is32 ? {sel_dword, sel_dword} : rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            tx_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: rtl/soff_sub_csr_regs.sv
// One SOFF sub-block's 64-bit CSR window on sub_csr_if.
//   offset 0 ID (RO), 1 CTRL (RW, bit0 = self-clearing start), 2 STATUS (W1C, sticky sets),
//   3 CYCLE (free-running, any write clears), 4.. ARGn (RW).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   csr         : sub_csr_if.to_afu, rx requests in, tx read responses out
//   status_set  : one-cycle set pulses into STATUS
//   start_o     : one-cycle pulse after a CTRL write with bit0 set
//   ctrl_o      : CTRL register (bit0 always 0)
//   args_o      : argument registers, arg0 in [63:0]
module soff_sub_csr_regs
    import soff_csr_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0040,
    parameter int unsigned NUM_ARGS  = 4,
    parameter logic [63:0] SUB_ID    = 64'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    sub_csr_if.to_afu              csr,
    input  logic [63:0]            status_set,
    output logic                   start_o,
    output logic [63:0]            ctrl_o,
    output logic [NUM_ARGS*64-1:0] args_o
);

    localparam int unsigned NUM_REGS = 4 + NUM_ARGS;
    localparam logic [16:0] WIN_END  = {1'b0, BASE_ADDR} + 17'(2 * NUM_REGS);

    t_csr_rx     rx;
    t_csr_tx     tx;
    logic        hit, is32, hi, size_ok, wr_en, rd_en;
    t_csr_idx    idx;
    logic [63:0] wmask, wdata, w1c;

    logic [63:0] ctrl_q, ctrl_d;
    logic [63:0] status_q, status_d;
    logic [63:0] cycle_q, cycle_d;
    logic        start_q, start_d;
    logic [63:0] args_q [NUM_ARGS];
    logic [63:0] args_d [NUM_ARGS];

    t_csr_rd_req rd_req;
    t_csr_idx    rd_idx;
    logic [63:0] rd_data;

    assign rx    = csr.rx;
    assign csr.tx = tx;

    // Request decode. BASE_ADDR is window-aligned, so address bit0 is the dword select.
    always_comb begin
        hit     = (rx.hdr.address >= BASE_ADDR) && ({1'b0, rx.hdr.address} < WIN_END);
        is32    = (rx.hdr.length == CCIP_LEN_4B);
        size_ok = is32 || (rx.hdr.length == CCIP_LEN_8B);
        hi      = is32 && rx.hdr.address[0];
        idx     = t_csr_idx'((rx.hdr.address - BASE_ADDR) >> 1);
        wr_en   = rx.wrValid && hit && size_ok;
        // A simultaneous write wins; the read is dropped.
        rd_en   = rx.rdValid && !rx.wrValid && hit && size_ok;
        wmask   = csr_lane_mask(is32, hi);
        wdata   = is32 ? {2{rx.data[31:0]}} : rx.data;
    end

    // Register next-state
    always_comb begin
        ctrl_d  = ctrl_q;
        cycle_d = cycle_q + 64'd1;
        start_d = 1'b0;
        w1c     = '0;
        for (int i = 0; i < int'(NUM_ARGS); i++) begin
            args_d[i] = args_q[i];
        end

        if (wr_en) begin
            if (idx == CSR_CTRL) begin
                ctrl_d    = (ctrl_q & ~wmask) | (wdata & wmask);
                start_d   = ctrl_d[0];
                ctrl_d[0] = 1'b0;
            end
            if (idx == CSR_STATUS) begin
                w1c = wdata & wmask;
            end
            if (idx == CSR_CYCLE) begin
                cycle_d = '0;
            end
            for (int i = 0; i < int'(NUM_ARGS); i++) begin
                if (idx == t_csr_idx'(int'(CSR_ARG0) + i)) begin
                    args_d[i] = (args_q[i] & ~wmask) | (wdata & wmask);
                end
            end
        end

        // Set is applied after clear so a coincident set wins.
        status_d = (status_q & ~w1c) | status_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            status_q <= '0;
            cycle_q  <= '0;
            start_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_ARGS); i++) begin
                args_q[i] <= '0;
            end
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            cycle_q  <= cycle_d;
            start_q  <= start_d;
            for (int i = 0; i < int'(NUM_ARGS); i++) begin
                args_q[i] <= args_d[i];
            end
        end
    end

    assign start_o = start_q;
    assign ctrl_o  = ctrl_q;

    always_comb begin
        args_o = '0;
        for (int i = 0; i < int'(NUM_ARGS); i++) begin
            args_o[i*64 +: 64] = args_q[i];
        end
    end

    // Read mux, indexed by the pipeline's stage-1 request
    always_comb begin
        rd_data = '0;
        case (rd_idx)
            CSR_ID:     rd_data = SUB_ID;
            CSR_CTRL:   rd_data = ctrl_q;
            CSR_STATUS: rd_data = status_q;
            CSR_CYCLE:  rd_data = cycle_q;
            default: begin
                for (int i = 0; i < int'(NUM_ARGS); i++) begin
                    if (rd_idx == t_csr_idx'(int'(CSR_ARG0) + i)) begin
                        rd_data = args_q[i];
                    end
                end
            end
        endcase
    end

    assign rd_req = '{idx: idx, hi: hi, is32: is32, tid: rx.hdr.tid};

    soff_csr_rd_pipe u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (rd_en),
        .req_i       (rd_req),
        .rd_idx_o    (rd_idx),
        .rd_data_i   (rd_data),
        .tx_o        (tx)
    );

`ifndef SYNTHESIS
    a_no_rd_wr: assert property (@(posedge clk) disable iff (reset)
        !(rx.rdValid && rx.wrValid))
        else $error("rdValid and wrValid asserted together");

    a_no_64b: assert property (@(posedge clk) disable iff (reset)
        !((rx.rdValid || rx.wrValid) && hit && (rx.hdr.length == CCIP_LEN_64B)))
        else $error("64B access to CSR window");
`endif

endmodule

// File: tb/tb_soff_sub_csr_regs.sv
module tb_soff_sub_csr_regs;
    import soff_csr_pkg::*;

    localparam logic [15:0] BASE  = 16'h0040;
    localparam int          NARGS = 4;
    localparam int          NREGS = 4 + NARGS;
    localparam logic [63:0] SUBID = 64'h5AB0_0000_1234_ABCD;

    logic                clk = 1'b0;
    logic                reset;
    logic [63:0]         status_set;
    logic                start_o;
    logic [63:0]         ctrl_o;
    logic [NARGS*64-1:0] args_o;

    sub_csr_if csr_bus ();

    soff_sub_csr_regs #(
        .BASE_ADDR (BASE),
        .NUM_ARGS  (NARGS),
        .SUB_ID    (SUBID)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .csr        (csr_bus),
        .status_set (status_set),
        .start_o    (start_o),
        .ctrl_o     (ctrl_o),
        .args_o     (args_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;          // step (negedge) index

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: architectural register contents as of the cycle after the last step.
    logic [63:0] m_ctrl, m_status, m_cycle;
    logic        m_start;
    logic [63:0] m_args [NARGS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @step %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [63:0] model_reg(input int idx);
        case (idx)
            0:       return SUBID;
            1:       return m_ctrl;
            2:       return m_status;
            3:       return m_cycle;
            default: return m_args[idx-4];
        endcase
    endfunction

    task automatic model_clear();
        m_ctrl = '0; m_status = '0; m_cycle = '0; m_start = 1'b0;
        for (int i = 0; i < NARGS; i++) m_args[i] = '0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        check("start_o", 64'(start_o), 64'(m_start));
        check("ctrl_o", ctrl_o, m_ctrl);
        for (int i = 0; i < NARGS; i++) begin
            check($sformatf("args_o[%0d]", i), args_o[i*64 +: 64], m_args[i]);
        end
        if (exp_q.size() > 0 && exp_q[0].due == k) begin
            check("rsp_valid", 64'(csr_bus.tx.mmioRdValid), 64'd1);
            check("rsp_tid", 64'(csr_bus.tx.hdr.tid), 64'(exp_q[0].tid));
            check("rsp_data", csr_bus.tx.data, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            check("idle_valid", 64'(csr_bus.tx.mmioRdValid), 64'd0);
            check("idle_data", csr_bus.tx.data, 64'd0);
        end
    endtask

    task automatic model_apply(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [1:0] len, input logic [8:0] tid,
                               input logic [63:0] data, input logic [63:0] set);
        logic        hit, okl, is32, hi;
        int          idx;
        logic [63:0] cur, nxt, w1c, v;
        logic [31:0] dw;
        hit  = (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + 2 * NREGS);
        okl  = (len == 2'b00) || (len == 2'b01);
        is32 = (len == 2'b00);
        hi   = addr[0];
        idx  = (int'(addr) - int'(BASE)) / 2;
        m_start = 1'b0;
        w1c     = '0;
        m_cycle = m_cycle + 64'd1;
        if (wr && hit && okl) begin
            cur = model_reg(idx);
            if (!is32)   nxt = data;
            else if (hi) nxt = {data[31:0], cur[31:0]};
            else         nxt = {cur[63:32], data[31:0]};
            case (idx)
                0: ;
                1: begin m_start = nxt[0]; m_ctrl = nxt & ~64'h1; end
                2: w1c = !is32 ? data : (hi ? {data[31:0], 32'h0} : {32'h0, data[31:0]});
                3: m_cycle = '0;
                default: m_args[idx-4] = nxt;
            endcase
        end
        m_status = (m_status & ~w1c) | set;
        if (rd && !wr && hit && okl) begin
            v = model_reg(idx);
            if (is32) begin
                dw = hi ? v[63:32] : v[31:0];
                v  = {dw, dw};
            end
            exp_q.push_back('{due: k + 2, tid: tid, data: v});
        end
    endtask

    task automatic step(input logic rst, input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data,
                        input logic [63:0] set);
        t_csr_rx rx;
        @(negedge clk);
        check_outputs();
        rx             = '0;
        rx.hdr.address = addr;
        rx.hdr.length  = len;
        rx.hdr.tid     = tid;
        rx.data        = data;
        rx.rdValid     = rd;
        rx.wrValid     = wr;
        reset          = rst;
        csr_bus.rx     = rx;
        status_set     = set;
        if (rst) model_clear();
        else     model_apply(rd, wr, addr, len, tid, data, set);
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0, 64'h0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
        step(1'b0, 1'b0, 1'b1, addr, len, 9'h0, data, 64'h0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid);
        step(1'b0, 1'b1, 1'b0, addr, len, tid, 64'h0, 64'h0);
    endtask

    initial begin
        logic [15:0] addr;
        logic [1:0]  len;
        logic [63:0] set;
        int          kind, r;

        reset      = 1'b1;
        csr_bus.rx = '0;
        status_set = '0;
        model_clear();

        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0, 64'h0);

        // ID read: response exactly two cycles later
        rd(BASE, CCIP_LEN_8B, 9'h05);
        idle(1);
        #6;
        check("id_valid", 64'(csr_bus.tx.mmioRdValid), 64'd1);
        check("id_tid", 64'(csr_bus.tx.hdr.tid), 64'h05);
        check("id_data", csr_bus.tx.data, SUBID);

        // ARG0 full and half writes, half read
        wr(BASE + 16'd8, CCIP_LEN_8B, 64'hDEAD_BEEF_0123_4567);
        #6 check("arg0_8b", args_o[63:0], 64'hDEAD_BEEF_0123_4567);
        wr(BASE + 16'd9, CCIP_LEN_4B, 64'h0000_0000_CAFE_F00D);
        #6 check("arg0_4b_hi", args_o[63:0], 64'hCAFE_F00D_0123_4567);
        rd(BASE + 16'd9, CCIP_LEN_4B, 9'h07);
        idle(1);
        #6 check("arg0_rd32", csr_bus.tx.data, 64'hCAFE_F00D_CAFE_F00D);

        // STATUS: set beats coincident clear, then plain clear
        step(1'b0, 1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0, 64'h5);
        step(1'b0, 1'b0, 1'b1, BASE + 16'd4, CCIP_LEN_8B, 9'h0, 64'h1, 64'h1);
        rd(BASE + 16'd4, CCIP_LEN_8B, 9'h10);
        idle(1);
        #6 check("status_set_wins", csr_bus.tx.data, 64'h5);
        wr(BASE + 16'd4, CCIP_LEN_8B, 64'h4);
        rd(BASE + 16'd4, CCIP_LEN_8B, 9'h11);
        idle(1);
        #6 check("status_w1c", csr_bus.tx.data, 64'h1);

        // CTRL start pulse
        wr(BASE + 16'd2, CCIP_LEN_8B, 64'h3);
        #6;
        check("start_pulse", 64'(start_o), 64'd1);
        check("ctrl_val", ctrl_o, 64'h2);
        idle(1);
        #6 check("start_clear", 64'(start_o), 64'd0);
        rd(BASE + 16'd2, CCIP_LEN_8B, 9'h12);
        idle(1);
        #6 check("ctrl_rd", csr_bus.tx.data, 64'h2);

        // Back-to-back reads, then a miss just past the window
        for (int i = 0; i < 4; i++) rd(BASE + 16'(2 * i), CCIP_LEN_8B, 9'(i + 1));
        rd(BASE + 16'(2 * NREGS), CCIP_LEN_8B, 9'h1F);
        rd(BASE - 16'd1, CCIP_LEN_8B, 9'h1E);
        idle(4);

        // Reset while a read is in flight
        rd(BASE + 16'd8, CCIP_LEN_8B, 9'h20);
        step(1'b1, 1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0, 64'h0);
        idle(4);
        #6 check("args_after_reset", args_o[63:0], 64'h0);

        // CYCLE wrap
        idle(1);
        force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFD;
        #1 release dut.cycle_q;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 4; i++) rd(BASE + 16'd6, CCIP_LEN_8B, 9'(8'h40 + i));
        idle(3);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 99);
            r    = $urandom_range(0, NREGS);
            if (r == NREGS) begin
                addr = ($urandom_range(0, 1) == 1) ? BASE + 16'(2 * NREGS + $urandom_range(0, 3))
                                                   : BASE - 16'(1 + $urandom_range(0, 3));
            end else begin
                addr = BASE + 16'(2 * r + $urandom_range(0, 1));
            end
            len = 2'($urandom_range(0, 1));
            set = ($urandom_range(0, 3) == 0) ?
                  ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : 64'h0;
            if (kind == 0)
                step(1'b1, 1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0, 64'h0);
            else if (kind < 45)
                step(1'b0, 1'b1, 1'b0, addr, len, 9'($urandom), 64'h0, set);
            else if (kind < 80)
                step(1'b0, 1'b0, 1'b1, addr, len, 9'h0, {$urandom, $urandom}, set);
            else
                step(1'b0, 1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0, set);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
